// File: rtl/im_access_ctrl_if.sv
// Bundle of loader, fetch and instruction-memory signals owned by im_access_ctrl.
// slave: the controller side; master: requesters plus the memory.
interface im_access_ctrl_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
);
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ack;
  logic              ld_done;
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_valid;
  logic [DATA_W-1:0] f_data;
  logic              cpu_hold;
  logic              we_im;
  logic [ADDR_W-1:0] add_im;
  logic [DATA_W-1:0] data_im_in;
  logic [DATA_W-1:0] out_im;

  modport slave (
    input  ld_req, ld_addr, ld_data, ld_done, f_req, f_addr, out_im,
    output ld_ack, f_gnt, f_valid, f_data, cpu_hold, we_im, add_im, data_im_in
  );

  modport master (
    output ld_req, ld_addr, ld_data, ld_done, f_req, f_addr, out_im,
    input  ld_ack, f_gnt, f_valid, f_data, cpu_hold, we_im, add_im, data_im_in
  );
endinterface

// File: rtl/im_access_ctrl.sv
// Boot sequencer and loader/fetch arbiter in front of instruction_mem.
// Define IMC_WRITE_PROTECT_EN to forbid loader writes after boot (adds wp_err).
module im_access_ctrl #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned MAX_BURST = 4
) (
  input logic              clk,
  input logic              rst_n,
  im_access_ctrl_if.slave  bus
`ifdef IMC_WRITE_PROTECT_EN
  ,
  output logic             wp_err
`endif
);

  typedef enum logic [0:0] {StBoot, StRun} state_e;

  state_e            state_q, state_d;
  logic              ld_win, f_win;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] add_q, add_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
  logic              f_valid_q;
  logic [DATA_W-1:0] f_data_q;

`ifndef IMC_WRITE_PROTECT_EN
  localparam int unsigned BurstW = 4;
  logic [BurstW-1:0] burst_q, burst_d;
`endif

  always_comb begin
    state_d = state_q;
    ld_win  = 1'b0;
    f_win   = 1'b0;
`ifndef IMC_WRITE_PROTECT_EN
    burst_d = '0;
`endif
    unique case (state_q)
      StBoot: begin
        // A write presented with ld_done still completes; RUN starts next cycle.
        ld_win = bus.ld_req;
        if (bus.ld_done) state_d = StRun;
      end
      StRun: begin
`ifdef IMC_WRITE_PROTECT_EN
        f_win = bus.f_req;
`else
        if (bus.f_req && (!bus.ld_req || burst_q == BurstW'(MAX_BURST))) begin
          f_win = 1'b1;
        end else begin
          ld_win = bus.ld_req;
        end
        if (ld_win && bus.f_req) burst_d = burst_q + BurstW'(1);
`endif
      end
      default: state_d = StBoot;
    endcase
  end

  always_comb begin
    we_d   = 1'b0;
    add_d  = add_q;
    data_d = data_q;
    if (ld_win) begin
      we_d   = 1'b1;
      add_d  = bus.ld_addr;
      data_d = bus.ld_data;
    end else if (f_win) begin
      add_d = bus.f_addr;
    end
    // Bit k set means a read address has been on add_im for k+1 edges.
    rd_pipe_d = (rd_pipe_q << 1) | RD_LAT'(f_win);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StBoot;
      we_q      <= 1'b0;
      add_q     <= '0;
      data_q    <= '0;
      rd_pipe_q <= '0;
      f_valid_q <= 1'b0;
      f_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      add_q     <= add_d;
      data_q    <= data_d;
      rd_pipe_q <= rd_pipe_d;
      f_valid_q <= rd_pipe_q[RD_LAT-1];
      if (rd_pipe_q[RD_LAT-1]) f_data_q <= bus.out_im;
    end
  end

`ifndef IMC_WRITE_PROTECT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      burst_q <= '0;
    end else begin
      burst_q <= burst_d;
    end
  end
`else
  assign wp_err = (state_q == StRun) && bus.ld_req;
`endif

  assign bus.ld_ack     = ld_win;
  assign bus.f_gnt      = f_win;
  assign bus.f_valid    = f_valid_q;
  assign bus.f_data     = f_data_q;
  assign bus.cpu_hold   = (state_q == StBoot);
  assign bus.we_im      = we_q;
  assign bus.add_im     = add_q;
  assign bus.data_im_in = data_q;

endmodule

// File: tb/tb_im_access_ctrl.sv
// Scoreboard bench for im_access_ctrl: expected memory writes and fetch returns are
// queued at grant time and matched by a negedge monitor.
module tb_im_access_ctrl;
  localparam int unsigned AW        = 12;
  localparam int unsigned DW        = 16;
  localparam int unsigned RD_LAT    = 1;
  localparam int unsigned MAX_BURST = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  im_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
`ifdef IMC_WRITE_PROTECT_EN
  logic wp_err;
`endif

  im_access_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef IMC_WRITE_PROTECT_EN
    .bus   (bus),
    .wp_err(wp_err)
`else
    .bus   (bus)
`endif
  );

  // Memory with a one-cycle read: out_im follows add_im within the cycle.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (bus.we_im) mem[bus.add_im] <= bus.data_im_in;
  assign bus.out_im = mem[bus.add_im];

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int unsigned   cyc;
  } exp_t;

  exp_t        wr_q[$];
  exp_t        rd_q[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (bus.we_im !== 1'b0) begin
      n_checks++;
      if (wr_q.size() == 0) begin
        n_fail++;
        $display("FAIL write_unexpected: we_im=%b add_im=%h data=%h, required no write",
                 bus.we_im, bus.add_im, bus.data_im_in);
      end else begin
        e = wr_q.pop_front();
        if (bus.add_im !== e.addr || bus.data_im_in !== e.data || cyc !== e.cyc) begin
          n_fail++;
          $display("FAIL write_port: got add=%h data=%h cyc=%0d, required add=%h data=%h cyc=%0d",
                   bus.add_im, bus.data_im_in, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
    if (bus.f_valid !== 1'b0) begin
      n_checks++;
      if (rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL fvalid_unexpected: f_valid=%b f_data=%h, required no f_valid",
                 bus.f_valid, bus.f_data);
      end else begin
        e = rd_q.pop_front();
        if (bus.f_data !== e.data || cyc !== e.cyc) begin
          n_fail++;
          $display("FAIL fetch_data: got data=%h cyc=%0d, required data=%h cyc=%0d",
                   bus.f_data, cyc, e.data, e.cyc);
        end
      end
    end
  end

  task automatic drive_idle();
    bus.ld_req  = 1'b0;
    bus.ld_addr = '0;
    bus.ld_data = '0;
    bus.ld_done = 1'b0;
    bus.f_req   = 1'b0;
    bus.f_addr  = '0;
  endtask

  task automatic cycle_start();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.addr = a; e.data = d; e.cyc = cyc + 1;
    wr_q.push_back(e);
  endtask

  task automatic push_rd(input logic [DW-1:0] d);
    exp_t e;
    e.addr = '0; e.data = d; e.cyc = cyc + 1 + RD_LAT;
    rd_q.push_back(e);
  endtask

  task automatic drain();
    int k = 0;
    while ((wr_q.size() != 0 || rd_q.size() != 0) && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    n_checks++;
    if (wr_q.size() != 0 || rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d writes and %0d reads outstanding, required 0",
               wr_q.size(), rd_q.size());
    end
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.cpu_hold !== 1'b1) begin
      n_fail++; $display("FAIL reset_hold: got %b, required 1", bus.cpu_hold);
    end
    n_checks++;
    if ({bus.we_im, bus.add_im, bus.data_im_in} !== '0) begin
      n_fail++;
      $display("FAIL reset_mem_port: got we=%b add=%h data=%h, required all 0",
               bus.we_im, bus.add_im, bus.data_im_in);
    end
    n_checks++;
    if ({bus.ld_ack, bus.f_gnt, bus.f_valid, bus.f_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ack=%b gnt=%b valid=%b data=%h, required all 0",
               bus.ld_ack, bus.f_gnt, bus.f_valid, bus.f_data);
    end
    cycle_start();
    rst_n = 1'b1;
  endtask

  task automatic test_boot_load();
    logic [AW-1:0] addrs [2];
    logic [DW-1:0] datas [2];
    addrs[0] = 12'h001; datas[0] = 16'h02A3;
    addrs[1] = 12'h002; datas[1] = 16'h00FF;
    for (int i = 0; i < 2; i++) begin
      cycle_start();
      bus.ld_req  = 1'b1;
      bus.ld_addr = addrs[i];
      bus.ld_data = datas[i];
      bus.f_req   = 1'b1;
      bus.f_addr  = 12'h005;
      @(negedge clk);
      n_checks++;
      if (bus.ld_ack !== 1'b1 || bus.f_gnt !== 1'b0 || bus.cpu_hold !== 1'b1) begin
        n_fail++;
        $display("FAIL boot_write%0d: got ack=%b gnt=%b hold=%b, required ack=1 gnt=0 hold=1",
                 i, bus.ld_ack, bus.f_gnt, bus.cpu_hold);
      end
      push_wr(addrs[i], datas[i]);
    end
    cycle_start();
    bus.ld_req  = 1'b0;
    bus.ld_done = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.ld_ack !== 1'b0 || bus.f_gnt !== 1'b0 || bus.cpu_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL boot_done_cycle: got ack=%b gnt=%b hold=%b, required ack=0 gnt=0 hold=1",
               bus.ld_ack, bus.f_gnt, bus.cpu_hold);
    end
    cycle_start();
    drive_idle();
    @(negedge clk);
    n_checks++;
    if (bus.cpu_hold !== 1'b0 || bus.we_im !== 1'b0 || bus.add_im !== 12'h002) begin
      n_fail++;
      $display("FAIL boot_to_run: got hold=%b we=%b add=%h, required hold=0 we=0 add=002",
               bus.cpu_hold, bus.we_im, bus.add_im);
    end
    drain();
  endtask

  task automatic test_fetch();
    logic [AW-1:0] addrs [2];
    logic [DW-1:0] datas [2];
    addrs[0] = 12'h001; datas[0] = 16'h02A3;
    addrs[1] = 12'h002; datas[1] = 16'h00FF;
    for (int i = 0; i < 2; i++) begin
      cycle_start();
      bus.f_req  = 1'b1;
      bus.f_addr = addrs[i];
      @(negedge clk);
      n_checks++;
      if (bus.f_gnt !== 1'b1) begin
        n_fail++; $display("FAIL fetch_gnt%0d: got %b, required 1", i, bus.f_gnt);
      end
      push_rd(datas[i]);
    end
    cycle_start();
    drive_idle();
    drain();
  endtask

`ifndef IMC_WRITE_PROTECT_EN
  task automatic test_fairness();
    int  k = 0;
    logic exp_f;
    for (int i = 0; i < 10; i++) begin
      cycle_start();
      bus.ld_req  = 1'b1;
      bus.ld_addr = 12'h100 + AW'(k);
      bus.ld_data = 16'hA000 + DW'(k);
      bus.f_req   = 1'b1;
      bus.f_addr  = 12'h001;
      @(negedge clk);
      exp_f = ((i % (MAX_BURST + 1)) == MAX_BURST);
      n_checks++;
      if (bus.ld_ack !== ~exp_f || bus.f_gnt !== exp_f) begin
        n_fail++;
        $display("FAIL fair_slot%0d: got ack=%b gnt=%b, required ack=%b gnt=%b",
                 i, bus.ld_ack, bus.f_gnt, ~exp_f, exp_f);
      end
      if (exp_f) begin
        push_rd(16'h02A3);
      end else begin
        push_wr(12'h100 + AW'(k), 16'hA000 + DW'(k));
        k++;
      end
    end
    cycle_start();
    drive_idle();
    drain();
  endtask

  task automatic test_read_after_write();
    cycle_start();
    bus.ld_req  = 1'b1;
    bus.ld_addr = 12'h010;
    bus.ld_data = 16'h1234;
    @(negedge clk);
    n_checks++;
    if (bus.ld_ack !== 1'b1) begin
      n_fail++; $display("FAIL raw_ack: got %b, required 1", bus.ld_ack);
    end
    push_wr(12'h010, 16'h1234);
    cycle_start();
    drive_idle();
    bus.f_req  = 1'b1;
    bus.f_addr = 12'h010;
    @(negedge clk);
    n_checks++;
    if (bus.f_gnt !== 1'b1) begin
      n_fail++; $display("FAIL raw_gnt: got %b, required 1", bus.f_gnt);
    end
    push_rd(16'h1234);
    cycle_start();
    drive_idle();
    drain();
  endtask
`else
  task automatic test_write_protect();
    for (int i = 0; i < 3; i++) begin
      cycle_start();
      bus.ld_req  = 1'b1;
      bus.ld_addr = 12'h001;
      bus.ld_data = 16'hDEAD;
      @(negedge clk);
      n_checks++;
      if (bus.ld_ack !== 1'b0 || wp_err !== 1'b1) begin
        n_fail++;
        $display("FAIL wp_cycle%0d: got ack=%b wp_err=%b, required ack=0 wp_err=1",
                 i, bus.ld_ack, wp_err);
      end
    end
    cycle_start();
    drive_idle();
    @(negedge clk);
    n_checks++;
    if (wp_err !== 1'b0) begin
      n_fail++; $display("FAIL wp_idle: got wp_err=%b, required 0", wp_err);
    end
    cycle_start();
    bus.f_req  = 1'b1;
    bus.f_addr = 12'h001;
    @(negedge clk);
    n_checks++;
    if (bus.f_gnt !== 1'b1) begin
      n_fail++; $display("FAIL wp_readback_gnt: got %b, required 1", bus.f_gnt);
    end
    push_rd(16'h02A3);
    cycle_start();
    drive_idle();
    drain();
  endtask
`endif

  task automatic test_reset_mid_read();
    cycle_start();
    bus.f_req  = 1'b1;
    bus.f_addr = 12'h002;
    @(negedge clk);
    n_checks++;
    if (bus.f_gnt !== 1'b1) begin
      n_fail++; $display("FAIL midrst_gnt: got %b, required 1", bus.f_gnt);
    end
    cycle_start();
    drive_idle();
    rst_n = 1'b0;
    cycle_start();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.f_valid !== 1'b0 || bus.we_im !== 1'b0 || bus.cpu_hold !== 1'b1) begin
        n_fail++;
        $display("FAIL midrst_state%0d: got valid=%b we=%b hold=%b, required 0 0 1",
                 i, bus.f_valid, bus.we_im, bus.cpu_hold);
      end
    end
    cycle_start();
    bus.f_req  = 1'b1;
    bus.f_addr = 12'h001;
    @(negedge clk);
    n_checks++;
    if (bus.f_gnt !== 1'b0) begin
      n_fail++; $display("FAIL midrst_boot_gnt: got %b, required 0", bus.f_gnt);
    end
    cycle_start();
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_boot_load();
    test_fetch();
`ifndef IMC_WRITE_PROTECT_EN
    test_fairness();
    test_read_after_write();
`else
    test_write_protect();
`endif
    test_reset_mid_read();
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
